// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the d16 memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 64;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  // One requester's view of a memory access
  typedef struct packed {
    logic              we;
    logic              byte_enable;
    logic              byte_select;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin grant; the grant index is updated into last_grant on i_update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant_c
);

  logic r_last_grant;
  logic w_grant;

  // Lone requester wins; on contention the port not granted last time wins
  always_comb begin
    w_grant = r_last_grant;
    case (i_req)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = r_last_grant;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (i_update) begin
      r_last_grant <= w_grant;
    end
  end

  assign o_grant_c = w_grant;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported mem block between instruction fetch and load/store:
// one issue cycle, then a response cycle that waits out mem_wait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte_enable,
  input  logic              d_byte_select,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte_enable,
  output logic              mem_byte_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait
);

  state_t   r_state;
  state_t   w_next;
  owner_t   r_owner;
  logic     r_oor;
  logic     w_grant;
  logic     w_update;
  owner_t   w_sel;
  mem_req_t w_if_bus;
  mem_req_t w_d_bus;
  mem_req_t w_sel_bus;
  logic     w_sel_oor;

  assign w_update = (r_state == IDLE) && !rst && (if_req || d_req);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .i_req     ({d_req, if_req}),
    .i_update  (w_update),
    .o_grant_c (w_grant)
  );

  // Fetch is always a word read; the selected port is the fresh winner in IDLE, the owner in RESP
  always_comb begin
    w_if_bus  = '{we: 1'b0, byte_enable: 1'b0, byte_select: 1'b0,
                  addr: if_addr, wdata: DATA_W'(0)};
    w_d_bus   = '{we: d_we, byte_enable: d_byte_enable, byte_select: d_byte_select,
                  addr: d_addr, wdata: d_wdata};
    w_sel     = (r_state == IDLE) ? owner_t'(w_grant) : r_owner;
    w_sel_bus = (w_sel == DATA) ? w_d_bus : w_if_bus;
    w_sel_oor = 32'(w_sel_bus.addr) >= MEM_WORDS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= FETCH;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_update) begin
        r_owner <= w_sel;
        r_oor   <= w_sel_oor;
      end
    end
  end

  // Byte controls and address stay on the bus in RESP since mem resamples them every edge
  always_comb begin
    w_next          = r_state;
    if_ack          = 1'b0;
    if_rdata        = DATA_W'(0);
    d_ack           = 1'b0;
    d_rdata         = DATA_W'(0);
    d_err           = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_byte_enable = 1'b0;
    mem_byte_select = 1'b0;
    mem_addr        = ADDR_W'(0);
    mem_wdata       = DATA_W'(0);
    case (r_state)
      IDLE: begin
        if (w_update) begin
          w_next          = RESP;
          mem_en          = !w_sel_oor;
          mem_we          = w_sel_bus.we;
          mem_byte_enable = w_sel_bus.byte_enable;
          mem_byte_select = w_sel_bus.byte_select;
          mem_addr        = w_sel_bus.addr;
          mem_wdata       = w_sel_bus.wdata;
        end
      end
      RESP: begin
        mem_addr        = w_sel_bus.addr;
        mem_byte_enable = w_sel_bus.byte_enable;
        mem_byte_select = w_sel_bus.byte_select;
        if (!mem_wait) begin
          w_next = IDLE;
          if (r_owner == FETCH) begin
            if_ack   = 1'b1;
            if_rdata = r_oor ? DATA_W'(0) : mem_rdata;
          end else begin
            d_ack   = 1'b1;
            d_err   = r_oor;
            d_rdata = (r_oor || d_we) ? DATA_W'(0) : mem_rdata;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, multi-cycle corner sequences and a
// randomized run against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte_enable;
  logic        d_byte_select;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic        mem_byte_enable;
  logic        mem_byte_select;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_wait;

  mem_arbiter #(.MEM_WORDS(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_ack          (if_ack),
    .if_rdata        (if_rdata),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_byte_enable   (d_byte_enable),
    .d_byte_select   (d_byte_select),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_ack           (d_ack),
    .d_rdata         (d_rdata),
    .d_err           (d_err),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_byte_enable (mem_byte_enable),
    .mem_byte_select (mem_byte_select),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_wait        (mem_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mem: synchronous access, byte reads return the lane in [7:0]
  logic [15:0] mem [64];
  logic [15:0] rd_word;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_en && mem_addr < 16'd64) begin
      rd_word <= mem[mem_addr[5:0]];
      if (mem_we) begin
        if (!mem_byte_enable)    mem[mem_addr[5:0]]       <= mem_wdata;
        else if (mem_byte_select) mem[mem_addr[5:0]][15:8] <= mem_wdata[7:0];
        else                      mem[mem_addr[5:0]][7:0]  <= mem_wdata[7:0];
      end
    end
  end

  assign mem_rdata = mem_byte_enable ? {8'h00, mem_byte_select ? rd_word[15:8] : rd_word[7:0]}
                                     : rd_word;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [5:0] a, input logic [15:0] v);
    ld_addr = a;
    ld_data = v;
    ld_en   = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          port;     // 0 = fetch, 1 = data
    bit          we;
    bit          be;
    bit          bs;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          we;
    bit          be;
    bit          bs;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  vec_t tbl[10];

  task automatic drive(input vec_t v);
    if_req        = !v.port;
    if_addr       = v.addr;
    d_req         = v.port;
    d_we          = v.we;
    d_byte_enable = v.be;
    d_byte_select = v.bs;
    d_addr        = v.addr;
    d_wdata       = v.wdata;
  endtask

  task automatic do_access(input vec_t v);
    logic [1:0] exp_ack;
    exp_ack = v.port ? 2'b01 : 2'b10;
    step();
    drive(v);
    mem_wait = 1'b0;
    #1;
    chk({v.name, "/issue_en"}, 32'(mem_en), 32'(v.addr < 16'd64));
    chk({v.name, "/issue_addr"}, 32'(mem_addr), 32'(v.addr));
    chk({v.name, "/issue_ctl"}, 32'({mem_we, mem_byte_enable, mem_byte_select}),
        32'({v.port & v.we, v.port & v.be, v.port & v.bs}));
    for (int w = 0; w < v.waits; w++) begin
      step();
      mem_wait = 1'b1;
      #1;
      chk({v.name, "/stall_ack"}, 32'({if_ack, d_ack}), 32'(0));
      chk({v.name, "/stall_bus"}, 32'({mem_en, mem_byte_enable, mem_byte_select, mem_addr}),
          32'({1'b0, v.port & v.be, v.port & v.bs, v.addr}));
    end
    step();
    mem_wait = 1'b0;
    #1;
    chk({v.name, "/ack"}, 32'({if_ack, d_ack}), 32'(exp_ack));
    chk({v.name, "/rdata"}, 32'(v.port ? d_rdata : if_rdata), 32'(v.exp_rdata));
    if (v.port) chk({v.name, "/err"}, 32'(d_err), 32'(v.exp_err));
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    chk({v.name, "/idle"}, 32'({mem_en, if_ack, d_ack}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          pend[2];
    acc_t        pa[2];
    bit          busy;
    bit          bport;
    bit          last;
    bit          inr;
    logic [15:0] edata;
    logic [15:0] w;
    bit          eerr;
    logic [15:0] sh[64];
    int          bad;

    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; mem_wait = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_byte_enable = 1'b0; d_byte_select = 1'b0; d_addr = '0; d_wdata = '0;

    tbl[0] = '{"fetch3",      1'b0, 1'b0, 1'b0, 1'b0, 16'd3,  16'h0000, 0, 16'hBEEF, 1'b0};
    tbl[1] = '{"bwr_hi5",     1'b1, 1'b1, 1'b1, 1'b1, 16'd5,  16'h0012, 0, 16'h0000, 1'b0};
    tbl[2] = '{"brd_hi5",     1'b1, 1'b0, 1'b1, 1'b1, 16'd5,  16'h0000, 0, 16'h0012, 1'b0};
    tbl[3] = '{"wrd5",        1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  16'h0000, 0, 16'h12BB, 1'b0};
    tbl[4] = '{"oor_wr64",    1'b1, 1'b1, 1'b0, 1'b0, 16'd64, 16'hFFFF, 0, 16'h0000, 1'b1};
    tbl[5] = '{"oor_fetch70", 1'b0, 1'b0, 1'b0, 1'b0, 16'd70, 16'h0000, 0, 16'h0000, 1'b0};
    tbl[6] = '{"brd_lo5_w3",  1'b1, 1'b0, 1'b1, 1'b0, 16'd5,  16'h0000, 3, 16'h00BB, 1'b0};
    tbl[7] = '{"wr63_w1",     1'b1, 1'b1, 1'b0, 1'b0, 16'd63, 16'h5A5A, 1, 16'h0000, 1'b0};
    tbl[8] = '{"fetch63_w2",  1'b0, 1'b0, 1'b0, 1'b0, 16'd63, 16'h0000, 2, 16'h5A5A, 1'b0};
    tbl[9] = '{"oor_rd64",    1'b1, 1'b0, 1'b0, 1'b0, 16'd64, 16'h0000, 0, 16'h0000, 1'b1};

    load(6'd1, 16'h1111);
    load(6'd2, 16'h2222);
    load(6'd3, 16'hBEEF);
    load(6'd5, 16'hAABB);
    load(6'd63, 16'h0000);

    // Contention from reset: DATA, FETCH, DATA, FETCH acked on cycles 1, 3, 5, 7
    if_req = 1'b1; if_addr = 16'd2;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 16'd1;
    step();
    #1;
    chk("reset/outputs", 32'({mem_en, mem_we, mem_addr, if_ack, d_ack, d_err}), 32'(0));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      else rst = 1'b0;
      #1;
      chk("cont/ack", 32'({if_ack, d_ack}), 32'({k % 4 == 3, k % 4 == 1}));
      if (k % 2 == 0) chk("cont/issue_addr", 32'(mem_addr), (k % 4 == 0) ? 32'd1 : 32'd2);
      if (k % 4 == 1) chk("cont/d_rdata", 32'(d_rdata), 32'h1111);
      if (k % 4 == 3) chk("cont/if_rdata", 32'(if_rdata), 32'h2222);
    end
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    chk("cont/idle", 32'({mem_en, if_ack, d_ack}), 32'(0));

    for (int i = 0; i < 10; i++) do_access(tbl[i]);
    chk("mem5_after_bytewrite", 32'(mem[5]), 32'h12BB);

    // Reset pulse while the data access is in its response cycle
    step();
    d_req = 1'b1; d_we = 1'b0; d_byte_enable = 1'b0; d_addr = 16'd1; if_addr = 16'd2;
    #1;
    chk("rstmid/issue", 32'({mem_en, mem_addr}), 32'({1'b1, 16'd1}));
    step();
    mem_wait = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid/outputs", 32'({if_ack, d_ack, mem_en, mem_addr}), 32'(0));
    step();
    if_req = 1'b1;
    rst = 1'b0;
    #1;
    chk("rstmid/data_wins", 32'({mem_en, mem_addr}), 32'({1'b1, 16'd1}));
    step();
    #1;
    chk("rstmid/ack", 32'({if_ack, d_ack, d_rdata}), 32'({2'b01, 16'h1111}));
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;

    // Randomized traffic against a transaction-level model
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sh[i] = 16'($urandom);
      load(6'(i), sh[i]);
    end
    step();
    rst = 1'b0;
    busy = 1'b0; last = 1'b0; bport = 1'b0; edata = '0; eerr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      pa[p]   = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    end
    for (int cyc = 0; cyc < 560; cyc++) begin
      step();
      if_req = pend[0]; if_addr = pa[0].addr;
      d_req = pend[1]; d_we = pa[1].we; d_byte_enable = pa[1].be;
      d_byte_select = pa[1].bs; d_addr = pa[1].addr; d_wdata = pa[1].wdata;
      mem_wait = ($urandom_range(0, 2) == 0);
      #1;
      if (busy) begin
        if (mem_wait) begin
          chk("rnd/stall_ack", 32'({if_ack, d_ack}), 32'(0));
          chk("rnd/stall_addr", 32'(mem_addr), 32'(pa[bport].addr));
        end else begin
          chk("rnd/ack", 32'({if_ack, d_ack}), bport ? 32'd1 : 32'd2);
          chk("rnd/rdata", 32'(bport ? d_rdata : if_rdata), 32'(edata));
          if (bport) chk("rnd/err", 32'(d_err), 32'(eerr));
          pend[bport] = 1'b0;
          busy = 1'b0;
        end
      end else if (pend[0] || pend[1]) begin
        bport = (pend[0] && pend[1]) ? ~last : pend[1];
        last  = bport;
        busy  = 1'b1;
        inr   = pa[bport].addr < 16'd64;
        chk("rnd/issue_en", 32'(mem_en), 32'(inr));
        chk("rnd/issue_addr", 32'(mem_addr), 32'(pa[bport].addr));
        w     = inr ? sh[pa[bport].addr[5:0]] : 16'h0000;
        eerr  = bport && !inr;
        if (!bport)            edata = w;
        else if (!pa[1].we)    edata = !inr ? 16'h0000 : !pa[1].be ? w
                                       : {8'h00, pa[1].bs ? w[15:8] : w[7:0]};
        else begin
          edata = 16'h0000;
          if (inr) begin
            if (!pa[1].be)     sh[pa[1].addr[5:0]]       = pa[1].wdata;
            else if (pa[1].bs) sh[pa[1].addr[5:0]][15:8] = pa[1].wdata[7:0];
            else               sh[pa[1].addr[5:0]][7:0]  = pa[1].wdata[7:0];
          end
        end
      end else begin
        chk("rnd/idle", 32'({mem_en, if_ack, d_ack}), 32'(0));
      end
      for (int p = 0; p < 2; p++) begin
        if (cyc < 500 && !pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]     = 1'b1;
          pa[p].addr  = 16'($urandom_range(0, 71));
          pa[p].we    = (p == 1) && $urandom_range(0, 1) == 1;
          pa[p].be    = (p == 1) && $urandom_range(0, 1) == 1;
          pa[p].bs    = (p == 1) && $urandom_range(0, 1) == 1;
          pa[p].wdata = (p == 1) ? 16'($urandom) : 16'h0000;
        end
      end
    end
    chk("rnd/drained", 32'({busy, pend[0], pend[1]}), 32'(0));
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    step();

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== sh[i]) bad++;
    chk("rnd/mem_contents", 32'(bad), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
